// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core (R/I-type ALU, shifts, loads/stores of word, half and
// byte width, beq/bne, j/jal/jr). Each instruction walks IF -> ID -> EX [-> MEM] [-> WB].
// Both memories use a req/ready handshake, so slow memories stretch IF or MEM by wait cycles.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), asynchronous active-low reset
//   imem_req_o/addr_o             fetch request, address = PC
//   imem_rdata_i/ready_i          instruction word, fetch complete
//   dmem_req_o/we_o/op_o          data request, 1=store, width (00 word, 01 half, 10 byte)
//   dmem_addr_o/wdata_o           data address (ALU result), store data (rt)
//   dmem_rdata_i/ready_i          raw load word, access complete
//   reg_sel_i/reg_data_o          debug register read port (combinational)
//   pc_o                          PC of the instruction in flight
//   retire_o                      one-cycle pulse when an instruction completes
//   cyc_cnt_o/ret_cnt_o           cycles since reset / instructions retired (wrapping)
module mc_cpu #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 imem_req_o,
    output logic [31:0]          imem_addr_o,
    input  logic [31:0]          imem_rdata_i,
    input  logic                 imem_ready_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [1:0]           dmem_op_o,
    output logic [31:0]          dmem_addr_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic [31:0]          dmem_rdata_i,
    input  logic                 dmem_ready_i,
    input  logic [4:0]           reg_sel_i,
    output logic [31:0]          reg_data_o,
    output logic [31:0]          pc_o,
    output logic                 retire_o,
    output logic [CNT_WIDTH-1:0] cyc_cnt_o,
    output logic [CNT_WIDTH-1:0] ret_cnt_o
);

    localparam logic [2:0] StIf  = 3'd0;
    localparam logic [2:0] StId  = 3'd1;
    localparam logic [2:0] StEx  = 3'd2;
    localparam logic [2:0] StMem = 3'd3;
    localparam logic [2:0] StWb  = 3'd4;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;

    localparam logic [1:0] MemW = 2'b00;
    localparam logic [1:0] MemH = 2'b01;
    localparam logic [1:0] MemB = 2'b10;

    // Architectural and pipeline-stage state
    logic [2:0]           state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [31:0]          alu_out_q, alu_out_d;
    logic [31:0]          mdr_q, mdr_d;
    logic [31:0]          rf_q [32];
    logic [CNT_WIDTH-1:0] cyc_cnt_q, ret_cnt_q;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];

    // Decode
    logic [3:0] alu_op;
    logic       src_imm, src_shamt, imm_zext, dst_rd;
    logic       is_alu, is_load, is_store, mem_sign;
    logic [1:0] mem_op;
    logic       is_beq, is_bne, is_j, is_jal, is_jr;

    always_comb begin
        alu_op    = AluAdd;
        src_imm   = 1'b0;
        src_shamt = 1'b0;
        imm_zext  = 1'b0;
        dst_rd    = 1'b0;
        is_alu    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        mem_sign  = 1'b1;
        mem_op    = MemW;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        case (opcode)
            6'h00: begin
                is_alu = 1'b1;
                dst_rd = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_op = AluAdd;
                    6'h22, 6'h23: alu_op = AluSub;
                    6'h24:        alu_op = AluAnd;
                    6'h25:        alu_op = AluOr;
                    6'h26:        alu_op = AluXor;
                    6'h27:        alu_op = AluNor;
                    6'h2a:        alu_op = AluSlt;
                    6'h2b:        alu_op = AluSltu;
                    6'h00: begin alu_op = AluSll; src_shamt = 1'b1; end
                    6'h02: begin alu_op = AluSrl; src_shamt = 1'b1; end
                    6'h03: begin alu_op = AluSra; src_shamt = 1'b1; end
                    6'h04:        alu_op = AluSll;
                    6'h06:        alu_op = AluSrl;
                    6'h07:        alu_op = AluSra;
                    6'h08: begin is_jr = 1'b1; is_alu = 1'b0; end
                    default:      is_alu = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin is_alu = 1'b1; src_imm = 1'b1; end
            6'h0a: begin is_alu = 1'b1; src_imm = 1'b1; alu_op = AluSlt; end
            6'h0b: begin is_alu = 1'b1; src_imm = 1'b1; alu_op = AluSltu; end
            6'h0c: begin is_alu = 1'b1; src_imm = 1'b1; imm_zext = 1'b1; alu_op = AluAnd; end
            6'h0d: begin is_alu = 1'b1; src_imm = 1'b1; imm_zext = 1'b1; alu_op = AluOr; end
            6'h0e: begin is_alu = 1'b1; src_imm = 1'b1; imm_zext = 1'b1; alu_op = AluXor; end
            6'h0f: begin is_alu = 1'b1; src_imm = 1'b1; alu_op = AluLui; end
            6'h20: begin is_load = 1'b1; src_imm = 1'b1; mem_op = MemB; end
            6'h21: begin is_load = 1'b1; src_imm = 1'b1; mem_op = MemH; end
            6'h23: begin is_load = 1'b1; src_imm = 1'b1; end
            6'h24: begin is_load = 1'b1; src_imm = 1'b1; mem_op = MemB; mem_sign = 1'b0; end
            6'h25: begin is_load = 1'b1; src_imm = 1'b1; mem_op = MemH; mem_sign = 1'b0; end
            6'h28: begin is_store = 1'b1; src_imm = 1'b1; mem_op = MemB; end
            6'h29: begin is_store = 1'b1; src_imm = 1'b1; mem_op = MemH; end
            6'h2b: begin is_store = 1'b1; src_imm = 1'b1; end
            6'h04: is_beq = 1'b1;
            6'h05: is_bne = 1'b1;
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            default: ;
        endcase
    end

    // ALU; for shifts the A operand carries the shift amount and B the value
    logic [31:0] imm32, alu_a, alu_b, alu_res;
    assign imm32 = imm_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    assign alu_a = src_shamt ? {27'd0, shamt} : a_q;
    assign alu_b = src_imm ? imm32 : b_q;

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            AluAdd:  alu_res = alu_a + alu_b;
            AluSub:  alu_res = alu_a - alu_b;
            AluAnd:  alu_res = alu_a & alu_b;
            AluOr:   alu_res = alu_a | alu_b;
            AluXor:  alu_res = alu_a ^ alu_b;
            AluNor:  alu_res = ~(alu_a | alu_b);
            AluSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            AluSltu: alu_res = {31'd0, alu_a < alu_b};
            AluSll:  alu_res = alu_b << alu_a[4:0];
            AluSrl:  alu_res = alu_b >> alu_a[4:0];
            AluSra:  alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            AluLui:  alu_res = {alu_b[15:0], 16'h0000};
            default: alu_res = 32'h0;
        endcase
    end

    // Next PC for control-flow instructions
    logic [31:0] pc_plus4, npc;
    logic        is_flow;
    assign pc_plus4 = pc_q + 32'd4;
    assign is_flow  = is_beq | is_bne | is_j | is_jal | is_jr;

    always_comb begin
        npc = pc_plus4;
        if ((is_beq && a_q == b_q) || (is_bne && a_q != b_q)) begin
            npc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        end else if (is_j || is_jal) begin
            npc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        end else if (is_jr) begin
            npc = a_q;
        end
    end

    // Load lane extraction: memory returns the whole aligned word
    logic [31:0] ld_shift, load_val;
    assign ld_shift = mdr_q >> {alu_out_q[1:0], 3'b000};

    always_comb begin
        load_val = mdr_q;
        if (mem_op == MemH) begin
            load_val = mem_sign ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                : {16'h0000, ld_shift[15:0]};
        end else if (mem_op == MemB) begin
            load_val = mem_sign ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                : {24'h000000, ld_shift[7:0]};
        end
    end

    // FSM
    logic        rf_we, retire;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'h0;
        retire    = 1'b0;
        case (state_q)
            StIf: begin
                if (imem_ready_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = StId;
                end
            end
            StId: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = StEx;
            end
            StEx: begin
                alu_out_d = alu_res;
                if (is_flow) begin
                    pc_d    = npc;
                    retire  = 1'b1;
                    state_d = StIf;
                    if (is_jal) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_plus4;
                    end
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_alu) begin
                    state_d = StWb;
                end else begin
                    // Unknown instruction: retire as a no-op
                    pc_d    = pc_plus4;
                    retire  = 1'b1;
                    state_d = StIf;
                end
            end
            StMem: begin
                if (dmem_ready_i) begin
                    if (is_store) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = StIf;
                    end else begin
                        mdr_d   = dmem_rdata_i;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = dst_rd ? rd : rt;
                rf_wdata = is_load ? load_val : alu_out_q;
                pc_d     = pc_plus4;
                retire   = 1'b1;
                state_d  = StIf;
            end
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIf;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_out_q <= 32'h0;
            mdr_q     <= 32'h0;
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            cyc_cnt_q <= cyc_cnt_q + CNT_WIDTH'(1);
            if (retire) begin
                ret_cnt_q <= ret_cnt_q + CNT_WIDTH'(1);
            end
            if (rf_we && rf_waddr != 5'd0) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Gating with rst_ni keeps the fetch request low for the whole reset, even though
    // the reset state is IF.
    assign imem_req_o   = rst_ni && (state_q == StIf);
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = (state_q == StMem);
    assign dmem_we_o    = is_store;
    assign dmem_op_o    = mem_op;
    assign dmem_addr_o  = alu_out_q;
    assign dmem_wdata_o = b_q;
    assign reg_data_o   = rf_q[reg_sel_i];
    assign pc_o         = pc_q;
    assign retire_o     = retire;
    assign cyc_cnt_o    = cyc_cnt_q;
    assign ret_cnt_o    = ret_cnt_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: behavioural req/ready memories with programmable wait cycles,
// plus a second core built with a 4-bit counter width that executes nops.
module tb_mc_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, reg_data, pc;
    logic [1:0]  dmem_op;
    logic [4:0]  reg_sel;
    logic [31:0] cyc_cnt, ret_cnt;

    logic [31:0] imem [64];
    bit   [31:0] dmem [64];
    int          imem_lat, dmem_lat;
    int          iw_cnt, dw_cnt;
    int          total = 0;
    int          bad = 0;

    assign imem_rdata = imem[imem_addr[7:2]];
    assign imem_ready = imem_req && (iw_cnt >= imem_lat);
    assign dmem_rdata = dmem[dmem_addr[7:2]];
    assign dmem_ready = dmem_req && (dw_cnt >= dmem_lat);

    always @(posedge clk) begin
        iw_cnt <= (imem_req && !imem_ready) ? iw_cnt + 1 : 0;
        dw_cnt <= (dmem_req && !dmem_ready) ? dw_cnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    mc_cpu #(.RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .imem_ready_i(imem_ready),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_op_o(dmem_op),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_rdata_i(dmem_rdata), .dmem_ready_i(dmem_ready),
        .reg_sel_i(reg_sel), .reg_data_o(reg_data), .pc_o(pc), .retire_o(retire),
        .cyc_cnt_o(cyc_cnt), .ret_cnt_o(ret_cnt)
    );

    // Narrow-counter instance fed with nops (0x00000000 = sll $0,$0,0)
    logic        n_imem_req, n_dmem_req, n_dmem_we, n_retire;
    logic [31:0] n_imem_addr, n_dmem_addr, n_dmem_wdata, n_reg_data, n_pc;
    logic [1:0]  n_dmem_op;
    logic [3:0]  n_cyc, n_ret;
    logic [31:0] n_zero = 32'h0;
    logic        n_one = 1'b1;
    logic [4:0]  n_sel = 5'd0;

    mc_cpu #(.RESET_PC(32'h0), .CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(n_imem_req), .imem_addr_o(n_imem_addr),
        .imem_rdata_i(n_zero), .imem_ready_i(n_one),
        .dmem_req_o(n_dmem_req), .dmem_we_o(n_dmem_we), .dmem_op_o(n_dmem_op),
        .dmem_addr_o(n_dmem_addr), .dmem_wdata_o(n_dmem_wdata),
        .dmem_rdata_i(n_zero), .dmem_ready_i(n_one),
        .reg_sel_i(n_sel), .reg_data_o(n_reg_data), .pc_o(n_pc), .retire_o(n_retire),
        .cyc_cnt_o(n_cyc), .ret_cnt_o(n_ret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Never both requests at once, on either core
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            assert (!(imem_req && dmem_req) && !(n_imem_req && n_dmem_req)) else begin
                bad++;
                $error("FAIL req_exclusive: observed imem/dmem=%b%b n=%b%b expected not both",
                       imem_req, dmem_req, n_imem_req, n_dmem_req);
            end
        end
    end

    // Runs one instruction; ends 1 time unit after the edge that commits it.
    task automatic run_instr(output int cyc, output int dreq, output logic [31:0] d_addr,
                             output logic [31:0] d_wdata, output logic d_we,
                             output logic d_stable);
        cyc = 0; dreq = 0; d_addr = 0; d_wdata = 0; d_we = 0; d_stable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (dmem_req) begin
                if (dreq == 0) begin
                    d_addr = dmem_addr; d_wdata = dmem_wdata; d_we = dmem_we;
                end else if (dmem_addr !== d_addr || dmem_wdata !== d_wdata
                             || dmem_we !== d_we) begin
                    d_stable = 1'b0;
                end
                dreq++;
            end
            if (retire) begin
                @(posedge clk);
                #1;
                return;
            end
        end
    endtask

    task automatic rd_reg(input logic [4:0] sel, output logic [31:0] val);
        reg_sel = sel;
        #1;
        val = reg_data;
    endtask

    int          cyc, dreq;
    logic [31:0] da, dw, rv;
    logic        dwe, dst;

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]  = 32'h20010005; // addi $1,$0,5
        imem[1]  = 32'h20220007; // addi $2,$1,7
        imem[2]  = 32'h00221820; // add  $3,$1,$2
        imem[3]  = 32'hAC030004; // sw   $3,4($0)
        imem[4]  = 32'h8C040004; // lw   $4,4($0)
        imem[5]  = 32'h10210002; // beq  $1,$1,+2 -> 0x20
        imem[6]  = 32'h20050BAD; // skipped
        imem[7]  = 32'h20050BAD; // skipped
        imem[8]  = 32'h14210002; // bne  $1,$1,+2 (not taken)
        imem[9]  = 32'h0C000010; // jal  0x40
        imem[10] = 32'hFC000000; // unknown opcode
        imem[11] = 32'h000138C0; // sll  $7,$1,3
        imem[12] = 32'hAC010008; // sw   $1,8($0)
        imem[16] = 32'h03E00008; // jr   $31
        rst_n = 1'b0; imem_lat = 0; dmem_lat = 0; reg_sel = 5'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_ret", ret_cnt, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_imem_addr", imem_addr, 32'h0);

        // Three ALU instructions, zero-wait memories
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("addi1_cycles", cyc, 4);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("addi2_cycles", cyc, 4);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("add_cycles", cyc, 4);
        chk("alu_cyc_cnt", cyc_cnt, 32'd12);
        chk("alu_ret_cnt", ret_cnt, 32'd3);
        chk("alu_pc", pc, 32'h0C);
        rd_reg(5'd3, rv);
        chk("reg3", rv, 32'h11);

        // Store then load with three data wait cycles
        dmem_lat = 3;
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("sw_cycles", cyc, 7);
        chk("sw_req_cycles", dreq, 4);
        chk("sw_addr", da, 32'h4);
        chk("sw_wdata", dw, 32'h11);
        chk("sw_we", {31'd0, dwe}, 32'd1);
        chk("sw_stable", {31'd0, dst}, 32'd1);
        chk("sw_mem", dmem[1], 32'h11);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("lw_cycles", cyc, 8);
        chk("lw_req_cycles", dreq, 4);
        chk("lw_we", {31'd0, dwe}, 32'd0);
        chk("lw_stable", {31'd0, dst}, 32'd1);
        rd_reg(5'd4, rv);
        chk("reg4", rv, 32'h11);

        // Control flow
        dmem_lat = 0;
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("beq_cycles", cyc, 3);
        chk("beq_pc", pc, 32'h20);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("bne_cycles", cyc, 3);
        chk("bne_pc", pc, 32'h24);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("jal_cycles", cyc, 3);
        chk("jal_pc", pc, 32'h40);
        rd_reg(5'd31, rv);
        chk("reg31", rv, 32'h28);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("jr_cycles", cyc, 3);
        chk("jr_pc", pc, 32'h28);
        rd_reg(5'd5, rv);
        chk("reg5_skipped", rv, 32'h0);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("unknown_cycles", cyc, 3);
        chk("unknown_pc", pc, 32'h2C);
        run_instr(cyc, dreq, da, dw, dwe, dst);
        chk("sll_cycles", cyc, 4);
        rd_reg(5'd7, rv);
        chk("reg7", rv, 32'h28);
        chk("flow_ret_cnt", ret_cnt, 32'd11);

        // Reset in the middle of a stalled store
        dmem_lat = 10;
        for (int k = 0; k < 20 && !dmem_req; k++) @(negedge clk);
        chk("abort_req_seen", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("abort_imem_req", {31'd0, imem_req}, 32'd0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_cyc", cyc_cnt, 32'd0);
        rd_reg(5'd1, rv);
        chk("abort_reg1", rv, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_store", dmem[2], 32'h0);

        // Counter wrap on the 4-bit instance
        dmem_lat = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("cnt4_15", {28'd0, n_cyc}, 32'd15);
        @(posedge clk);
        #1;
        chk("cnt4_wrap0", {28'd0, n_cyc}, 32'd0);
        @(posedge clk);
        #1;
        chk("cnt4_wrap1", {28'd0, n_cyc}, 32'd1);
        chk("cnt4_ret", {28'd0, n_ret}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
